// File: rtl/rv_imem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder.
// Holds the NOP word, the wait-counter width and the fetch FSM encoding.
package rv_imem_responder_pkg;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam int unsigned IMEM_CNT_W = 4;

  typedef enum logic [1:0] {
    IMEM_IDLE   = 2'd0,
    IMEM_ACCESS = 2'd1,
    IMEM_VALID  = 2'd2
  } imem_state_e;

  // Word indices are 30 bits wide; compare them as 32-bit unsigned values.
  function automatic logic word_in_range(input logic [29:0] word, input int unsigned depth);
    return ({2'b00, word} < depth);
  endfunction

endpackage

// File: rtl/rv_imem_responder_ram.sv
// Single-port synchronous word RAM: one-cycle registered read, write-first.
// The fetch side and the host loader share this one port.
module rv_imem_responder_ram #(
  parameter int unsigned g_depth = 1024,
  localparam int unsigned c_aw   = $clog2(g_depth)
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [c_aw-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [g_depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_imem_responder.sv
// Fetch-port responder in front of program RAM, with programmable wait states,
// host write priority, write/fetch coherence and out-of-range NOP substitution.
module rv_imem_responder
  import rv_imem_responder_pkg::*;
#(
  parameter int unsigned g_depth       = 1024,
  parameter int unsigned g_wait_states = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_data_i,
  output logic        host_wack_o,
  output logic        bad_addr_o
);

  localparam int unsigned c_aw = $clog2(g_depth);
  localparam logic [IMEM_CNT_W-1:0] c_wait = IMEM_CNT_W'(g_wait_states);

  imem_state_e state_q, state_d;
  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic [29:0] cur_q, cur_d;
  logic valid_q, valid_d;
  logic bad_q, bad_d;
  logic fresh_q, fresh_d;
  logic oor_q, oor_d;
  logic wack_q;
  logic [31:0] hold_q;
  logic [31:0] ram_rdata;

  logic [29:0] fetch_word, host_word;
  logic host_wr, fetch_inr, restart, issue;
  logic ram_en, ram_we;
  logic [c_aw-1:0] ram_addr;
  logic unused_addr_bits;

  assign fetch_word       = im_addr_i[31:2];
  assign host_word        = host_addr_i[31:2];
  assign unused_addr_bits = ^{im_addr_i[1:0], host_addr_i[1:0]};
  assign host_wr          = host_we_i && word_in_range(host_word, g_depth);
  assign fetch_inr        = word_in_range(fetch_word, g_depth);

  // A write to the word being fetched restarts the access so the new value is seen.
  assign restart = (state_q == IMEM_IDLE) || (fetch_word != cur_q) ||
                   (host_wr && (host_word == fetch_word));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    oor_d   = oor_q;
    bad_d   = 1'b0;
    fresh_d = 1'b0;
    issue   = 1'b0;
    cnt_eff = '0;
    if (restart) begin
      cnt_eff = c_wait;
      cur_d   = fetch_word;
    end else if (cnt_q != '0) begin
      cnt_eff = cnt_q - 1'b1;
    end
    if (restart || (state_q == IMEM_ACCESS)) begin
      // Host writes own the port; an in-range read due now slips one edge.
      if ((cnt_eff == '0) && !(host_wr && fetch_inr)) begin
        issue   = 1'b1;
        state_d = IMEM_VALID;
        cnt_d   = '0;
        valid_d = 1'b1;
        fresh_d = fetch_inr;
        oor_d   = !fetch_inr;
        bad_d   = !fetch_inr;
      end else begin
        state_d = IMEM_ACCESS;
        cnt_d   = cnt_eff;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      fresh_q <= 1'b0;
      oor_q   <= 1'b0;
      wack_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      fresh_q <= fresh_d;
      oor_q   <= oor_d;
      wack_q  <= host_we_i;
      if (fresh_q) begin
        hold_q <= ram_rdata;
      end
    end
  end

  assign ram_we   = !rst_i && host_wr;
  assign ram_en   = !rst_i && (host_wr || (issue && fetch_inr));
  assign ram_addr = host_wr ? host_word[c_aw-1:0] : fetch_word[c_aw-1:0];

  rv_imem_responder_ram #(
    .g_depth(g_depth)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(host_data_i),
    .rdata_o(ram_rdata)
  );

  // The RAM output is live only right after a read; later writes overwrite it, so hold a copy.
  always_comb begin
    im_data_o = '0;
    if (valid_q) begin
      if (oor_q) begin
        im_data_o = RV_NOP;
      end else if (fresh_q) begin
        im_data_o = ram_rdata;
      end else begin
        im_data_o = hold_q;
      end
    end
  end

  assign im_valid_o  = valid_q;
  assign bad_addr_o  = bad_q;
  assign host_wack_o = wack_q;

endmodule

// File: tb/tb_rv_imem_responder.sv
// Three responders (0, 2 and 3 wait states) share one stimulus stream and are
// compared every cycle against an edge-numbered model of fetch timing.
module tb_rv_imem_responder;

  localparam int unsigned c_depth = 64;
  localparam int unsigned c_aw    = 6;
  localparam logic [31:0] c_nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_data;
  logic [31:0] im_data [3];
  logic        im_valid [3];
  logic        host_wack [3];
  logic        bad_addr [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      rv_imem_responder #(
        .g_depth      (c_depth),
        .g_wait_states((gi == 0) ? 0 : gi + 1)
      ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .im_addr_i  (im_addr),
        .im_data_o  (im_data[gi]),
        .im_valid_o (im_valid[gi]),
        .host_we_i  (host_we),
        .host_addr_i(host_addr),
        .host_data_i(host_data),
        .host_wack_o(host_wack[gi]),
        .bad_addr_o (bad_addr[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each fetch becomes ready at an absolute edge number.
  int          ws [3] = '{0, 2, 3};
  bit          m_act [3];
  logic [29:0] m_word [3];
  int          m_due [3];
  bit          m_rd [3];
  int          m_rd_edge [3];
  logic [31:0] m_data [3];
  logic [31:0] mem_model [c_depth];
  int          edge_n = 0;
  bit          exp_wack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [29:0] fw;
    logic [29:0] hw;
    bit wr_in;
    bit f_in;
    fw    = im_addr[31:2];
    hw    = host_addr[31:2];
    wr_in = host_we && !rst && ({2'b00, hw} < c_depth);
    edge_n++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_act[d] = 1'b0;
        m_rd[d]  = 1'b0;
      end else begin
        if (!m_act[d] || (fw != m_word[d]) || (wr_in && (hw == fw))) begin
          m_act[d]  = 1'b1;
          m_word[d] = fw;
          m_due[d]  = edge_n + ws[d];
          m_rd[d]   = 1'b0;
        end
        f_in = ({2'b00, fw} < c_depth);
        if (!m_rd[d] && (edge_n >= m_due[d]) && !(wr_in && f_in)) begin
          m_rd[d]      = 1'b1;
          m_rd_edge[d] = edge_n;
          m_data[d]    = f_in ? mem_model[fw[c_aw-1:0]] : c_nop;
        end
      end
    end
    exp_wack = host_we && !rst;
    if (exp_wack) begin
      $display("host write addr=%08h data=%08h", host_addr, host_data);
    end
    if (wr_in) begin
      mem_model[hw[c_aw-1:0]] = host_data;
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("ws%0d_valid", ws[d]), 32'(im_valid[d]), 32'(m_rd[d]));
      check_eq($sformatf("ws%0d_data", ws[d]), im_data[d], m_rd[d] ? m_data[d] : 32'h0);
      check_eq($sformatf("ws%0d_bad", ws[d]), 32'(bad_addr[d]),
               32'(m_rd[d] && ({2'b00, m_word[d]} >= c_depth) && (m_rd_edge[d] == edge_n)));
      check_eq($sformatf("ws%0d_wack", ws[d]), 32'(host_wack[d]), 32'(exp_wack));
    end
  endtask

  initial begin
    int hold;
    for (int d = 0; d < 3; d++) begin
      m_act[d] = 1'b0;
      m_rd[d]  = 1'b0;
      m_word[d] = '0;
    end
    rst       = 1'b1;
    im_addr   = 32'h0;
    host_we   = 1'b0;
    host_addr = 32'h0;
    host_data = 32'h0;
    @(negedge clk);
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check_eq("reset_valid", 32'(im_valid[d]), 32'h0);
      check_eq("reset_data", im_data[d], 32'h0);
    end
    rst = 1'b0;

    // Preload: word i holds 11*(i+1).
    for (int i = 0; i < int'(c_depth); i++) begin
      host_we   = 1'b1;
      host_addr = 32'(i * 4);
      host_data = 32'((i + 1) * 11);
      tick();
    end
    host_we = 1'b0;
    tick();

    // Back-to-back fetches with no wait states.
    im_addr = 32'h0; tick(); check_eq("t1_d0", im_data[0], 32'd11);
    im_addr = 32'h4; tick(); check_eq("t1_d1", im_data[0], 32'd22);
    im_addr = 32'h8; tick(); check_eq("t1_d2", im_data[0], 32'd33);
    check_eq("t1_valid", 32'(im_valid[0]), 32'h1);

    // Two wait states on a held address.
    im_addr = 32'hC; tick();
    im_addr = 32'h8;
    tick(); check_eq("t2_wait1", 32'(im_valid[1]), 32'h0);
    tick(); check_eq("t2_wait2", 32'(im_valid[1]), 32'h0);
    tick(); check_eq("t2_valid", 32'(im_valid[1]), 32'h1);
    check_eq("t2_data", im_data[1], 32'd33);
    tick(); check_eq("t2_held", im_data[1], 32'd33);

    // Address change during the access restarts the count.
    im_addr = 32'h4; tick(); tick();
    check_eq("t3_none", 32'(im_valid[2]), 32'h0);
    im_addr = 32'hC;
    tick(); tick(); tick();
    check_eq("t3_wait", 32'(im_valid[2]), 32'h0);
    tick();
    check_eq("t3_valid", 32'(im_valid[2]), 32'h1);
    check_eq("t3_data", im_data[2], 32'd44);

    // Host write to the word being served.
    im_addr = 32'h4; tick();
    host_we = 1'b1; host_addr = 32'h4; host_data = 32'hDEAD_BEEF;
    tick();
    host_we = 1'b0;
    check_eq("t4_wack", 32'(host_wack[0]), 32'h1);
    check_eq("t4_drop", 32'(im_valid[0]), 32'h0);
    tick();
    check_eq("t4_valid", 32'(im_valid[0]), 32'h1);
    check_eq("t4_data", im_data[0], 32'hDEAD_BEEF);

    // Out-of-range fetch.
    im_addr = 32'(4 * c_depth); tick();
    check_eq("t5_nop", im_data[0], c_nop);
    check_eq("t5_bad", 32'(bad_addr[0]), 32'h1);
    tick();
    check_eq("t5_bad_once", 32'(bad_addr[0]), 32'h0);

    // Reset in the middle of an access.
    im_addr = 32'h14; tick(); tick();
    rst = 1'b1; tick();
    check_eq("t6_rst_valid", 32'(im_valid[2]), 32'h0);
    check_eq("t6_rst_data", im_data[2], 32'h0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_eq("t6_wait", 32'(im_valid[2]), 32'h0);
    tick();
    check_eq("t6_valid", 32'(im_valid[2]), 32'h1);
    check_eq("t6_data", im_data[2], 32'd66);

    // Random fetch/write/reset mix.
    hold = 0;
    for (int n = 0; n < 2000; n++) begin
      if (hold == 0) begin
        hold = int'($urandom_range(1, 6));
        case ($urandom_range(0, 9))
          0:       im_addr = 32'(4 * c_depth + 4 * $urandom_range(0, 2));
          1:       im_addr = 32'hFFFF_FFF0;
          default: im_addr = 32'(4 * $urandom_range(0, 7));
        endcase
        im_addr[1:0] = 2'($urandom_range(0, 3));
      end
      hold--;
      host_we = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) begin
        host_addr = 32'(4 * c_depth + 4 * $urandom_range(0, 3));
      end else begin
        host_addr = 32'(4 * $urandom_range(0, 7));
      end
      host_addr[1:0] = 2'($urandom_range(0, 3));
      host_data = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst     = 1'b0;
    host_we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
